// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing generator with pixel-clock divider
// All outputs are registered from next-state values so they align with hCount/vCount.
module vga_timing_ctrl #(
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int H_ACT   = 640,
   parameter int H_FP    = 16,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter int V_ACT   = 480,
   parameter int V_FP    = 10,
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       pix_tick,
   output logic       line_start,
   output logic       frame_start
);

   localparam int         H_TOT       = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int         V_TOT       = V_SYNC + V_BP + V_ACT + V_FP;
   localparam logic [9:0] H_LAST      = 10'(H_TOT - 1);
   localparam logic [9:0] H_BP_START  = 10'(H_SYNC);
   localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_FP_START  = 10'(H_SYNC + H_BP + H_ACT);
   localparam logic [9:0] V_LAST      = 10'(V_TOT - 1);
   localparam logic [9:0] V_BP_START  = 10'(V_SYNC);
   localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_FP_START  = 10'(V_SYNC + V_BP + V_ACT);
   localparam logic [3:0] DIV_LAST    = 4'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_BP   = 2'd1,
      ST_ACT  = 2'd2,
      ST_FP   = 2'd3
   } state_t;

   logic [3:0] r_div;
   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;
   state_t     r_h_state;
   state_t     r_v_state;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_video_on;
   logic [9:0] r_pixel_x;
   logic [9:0] r_pixel_y;
   logic       r_pix_tick;
   logic       r_line_start;
   logic       r_frame_start;

   logic       w_tick;
   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_line_wrap;
   logic [9:0] w_h_nxt;
   logic [9:0] w_v_nxt;
   state_t     w_h_state_nxt;
   state_t     w_v_state_nxt;
   logic       w_video_nxt;
   logic       w_hsync_nxt;
   logic       w_vsync_nxt;
   logic [9:0] w_px_nxt;
   logic [9:0] w_py_nxt;

   always_comb begin
      w_tick      = en && (r_div == DIV_LAST);
      w_h_wrap    = (r_h_cnt == H_LAST);
      w_v_wrap    = (r_v_cnt == V_LAST);
      w_line_wrap = w_tick && w_h_wrap;
      w_h_nxt     = r_h_cnt;
      w_v_nxt     = r_v_cnt;
      if (w_tick) begin
         w_h_nxt = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
      end
      if (w_line_wrap) begin
         w_v_nxt = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= 4'd0;
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
      end else begin
         if (en) begin
            r_div <= (r_div == DIV_LAST) ? 4'd0 : r_div + 4'd1;
         end
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_state <= ST_SYNC;
         r_v_state <= ST_SYNC;
      end else begin
         r_h_state <= w_h_state_nxt;
         r_v_state <= w_v_state_nxt;
      end
   end

   // States only move on the tick whose next count lands on a region boundary.
   always_comb begin
      w_h_state_nxt = r_h_state;
      if (w_tick) begin
         case (r_h_state)
            ST_SYNC: if (w_h_nxt == H_BP_START)  w_h_state_nxt = ST_BP;
            ST_BP:   if (w_h_nxt == H_ACT_START) w_h_state_nxt = ST_ACT;
            ST_ACT:  if (w_h_nxt == H_FP_START)  w_h_state_nxt = ST_FP;
            ST_FP:   if (w_h_nxt == 10'd0)       w_h_state_nxt = ST_SYNC;
            default: w_h_state_nxt = ST_SYNC;
         endcase
      end
      w_v_state_nxt = r_v_state;
      if (w_line_wrap) begin
         case (r_v_state)
            ST_SYNC: if (w_v_nxt == V_BP_START)  w_v_state_nxt = ST_BP;
            ST_BP:   if (w_v_nxt == V_ACT_START) w_v_state_nxt = ST_ACT;
            ST_ACT:  if (w_v_nxt == V_FP_START)  w_v_state_nxt = ST_FP;
            ST_FP:   if (w_v_nxt == 10'd0)       w_v_state_nxt = ST_SYNC;
            default: w_v_state_nxt = ST_SYNC;
         endcase
      end
   end

   always_comb begin
      w_video_nxt = (w_h_state_nxt == ST_ACT) && (w_v_state_nxt == ST_ACT);
      w_hsync_nxt = (w_h_nxt >= H_BP_START);
      w_vsync_nxt = (w_v_nxt >= V_BP_START);
      w_px_nxt    = 10'd0;
      w_py_nxt    = 10'd0;
      if (w_video_nxt) begin
         w_px_nxt = w_h_nxt - H_ACT_START;
         w_py_nxt = w_v_nxt - V_ACT_START;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_video_on    <= 1'b0;
         r_pixel_x     <= 10'd0;
         r_pixel_y     <= 10'd0;
         r_pix_tick    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_video_on    <= w_video_nxt;
         r_pixel_x     <= w_px_nxt;
         r_pixel_y     <= w_py_nxt;
         r_pix_tick    <= w_tick;
         r_line_start  <= w_line_wrap;
         r_frame_start <= w_line_wrap && w_v_wrap;
      end
   end

   assign hCount      = r_h_cnt;
   assign vCount      = r_v_cnt;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video_on;
   assign pixel_x     = r_pixel_x;
   assign pixel_y     = r_pixel_y;
   assign pix_tick    = r_pix_tick;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed bench for vga_timing_ctrl
// Vertical geometry is shortened (11 lines) so whole frames fit a short run.
module tb_vga_timing_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, en, rst_n2;
   logic [9:0] hCount, vCount, pixel_x, pixel_y;
   logic       hsync, vsync, video_on, pix_tick, line_start, frame_start;
   logic [9:0] hCount2, vCount2, pixel_x2, pixel_y2;
   logic       hsync2, vsync2, video_on2, pix_tick2, line_start2, frame_start2;

   int n_errors, n_checks;
   int clks, ticks, lstarts, fstarts, model_bad, ls_bad, lows, hmax, vmax;
   logic found, saw_last;
   logic rec_hs95, rec_hs96, rec_vo143, rec_vo144, rec_vo783, rec_vo784;
   logic [9:0] rec_px144, rec_px783, rec_py5, rec_py8;
   logic rec_vs0, rec_vs1, rec_vs2, rec_vo_v4, rec_vo_v5, rec_vo_v8, rec_vo_v9;
   logic exp_hs, exp_vs, exp_vo;
   logic [9:0] exp_px, exp_py;

   always #5 clk = ~clk;

   vga_timing_ctrl #(
      .H_SYNC(96), .H_BP(48), .H_ACT(640), .H_FP(16),
      .V_SYNC(2), .V_BP(3), .V_ACT(4), .V_FP(2), .CLK_DIV(2)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .hCount(hCount), .vCount(vCount), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pix_tick(pix_tick), .line_start(line_start), .frame_start(frame_start)
   );

   vga_timing_ctrl #(
      .H_SYNC(96), .H_BP(48), .H_ACT(640), .H_FP(16),
      .V_SYNC(2), .V_BP(3), .V_ACT(4), .V_FP(2), .CLK_DIV(1)
   ) u_dut_div1 (
      .clk(clk), .rst_n(rst_n2), .en(1'b1),
      .hCount(hCount2), .vCount(vCount2), .hsync(hsync2), .vsync(vsync2),
      .video_on(video_on2), .pixel_x(pixel_x2), .pixel_y(pixel_y2),
      .pix_tick(pix_tick2), .line_start(line_start2), .frame_start(frame_start2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      n_errors = 0;
      n_checks = 0;
      en       = 1'b1;
      rst_n    = 1'b0;
      rst_n2   = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_hcount", hCount, 0);
      check("rst_vcount", vCount, 0);
      check("rst_hsync", hsync, 0);
      check("rst_vsync", vsync, 0);
      check("rst_video_on", video_on, 0);
      check("rst_pixel_x", pixel_x, 0);
      check("rst_pixel_y", pixel_y, 0);
      check("rst_pix_tick", pix_tick, 0);
      check("rst_line_start", line_start, 0);
      check("rst_frame_start", frame_start, 0);

      // First tick lands CLK_DIV=2 edges after release
      rst_n = 1'b1;
      @(negedge clk);
      check("lat_edge1_tick", pix_tick, 0);
      check("lat_edge1_hcount", hCount, 0);
      @(negedge clk);
      check("lat_edge2_tick", pix_tick, 1);
      check("lat_edge2_hcount", hCount, 1);

      found = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (frame_start) begin
            found = 1'b1;
            break;
         end
      end
      check("first_frame_seen", found, 1);

      clks = 0; ticks = 0; lstarts = 0; fstarts = 0; model_bad = 0; ls_bad = 0;
      hmax = 0; vmax = 0; saw_last = 1'b0; found = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         clks++;
         if (pix_tick) ticks++;
         if (line_start) lstarts++;
         if (frame_start) fstarts++;
         if (line_start && hCount != 10'd0) ls_bad++;
         if (int'(hCount) > hmax) hmax = int'(hCount);
         if (int'(vCount) > vmax) vmax = int'(vCount);
         exp_hs = (hCount >= 10'd96);
         exp_vs = (vCount >= 10'd2);
         exp_vo = (hCount >= 10'd144) && (hCount <= 10'd783) &&
                  (vCount >= 10'd5) && (vCount <= 10'd8);
         exp_px = exp_vo ? hCount - 10'd144 : 10'd0;
         exp_py = exp_vo ? vCount - 10'd5 : 10'd0;
         if (hsync !== exp_hs || vsync !== exp_vs || video_on !== exp_vo ||
             pixel_x !== exp_px || pixel_y !== exp_py) model_bad++;
         if (vCount == 10'd5) begin
            case (hCount)
               10'd95:  rec_hs95 = hsync;
               10'd96:  rec_hs96 = hsync;
               10'd143: rec_vo143 = video_on;
               10'd144: begin rec_vo144 = video_on; rec_px144 = pixel_x; end
               10'd783: begin rec_vo783 = video_on; rec_px783 = pixel_x; end
               10'd784: rec_vo784 = video_on;
               default: ;
            endcase
         end
         if (hCount == 10'd0) begin
            case (vCount)
               10'd0: rec_vs0 = vsync;
               10'd1: rec_vs1 = vsync;
               10'd2: rec_vs2 = vsync;
               default: ;
            endcase
         end
         if (hCount == 10'd200) begin
            case (vCount)
               10'd4: rec_vo_v4 = video_on;
               10'd5: begin rec_vo_v5 = video_on; rec_py5 = pixel_y; end
               10'd8: begin rec_vo_v8 = video_on; rec_py8 = pixel_y; end
               10'd9: rec_vo_v9 = video_on;
               default: ;
            endcase
         end
         if (hCount == 10'd799 && vCount == 10'd10) saw_last = 1'b1;
         if (frame_start) begin
            found = 1'b1;
            break;
         end
      end
      check("frame_seen", found, 1);
      check("frame_clks", clks, 800 * 11 * 2);
      check("frame_ticks", ticks, 800 * 11);
      check("frame_line_starts", lstarts, 11);
      check("frame_frame_starts", fstarts, 1);
      check("line_start_off_zero", ls_bad, 0);
      check("model_mismatch_samples", model_bad, 0);
      check("hcount_max", hmax, 799);
      check("vcount_max", vmax, 10);
      check("hsync_at_95", rec_hs95, 0);
      check("hsync_at_96", rec_hs96, 1);
      check("video_at_143", rec_vo143, 0);
      check("video_at_144", rec_vo144, 1);
      check("pixel_x_at_144", rec_px144, 0);
      check("video_at_783", rec_vo783, 1);
      check("pixel_x_at_783", rec_px783, 639);
      check("video_at_784", rec_vo784, 0);
      check("vsync_row0", rec_vs0, 0);
      check("vsync_row1", rec_vs1, 0);
      check("vsync_row2", rec_vs2, 1);
      check("video_row4", rec_vo_v4, 0);
      check("video_row5", rec_vo_v5, 1);
      check("pixel_y_row5", rec_py5, 0);
      check("video_row8", rec_vo_v8, 1);
      check("pixel_y_row8", rec_py8, 3);
      check("video_row9", rec_vo_v9, 0);
      check("wrap_from_last", saw_last, 1);
      check("wrap_hcount", hCount, 0);
      check("wrap_vcount", vCount, 0);

      // Freeze mid-line in an active row
      found = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (pix_tick && hCount == 10'd300 && vCount == 10'd5) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_h300", found, 1);
      en = 1'b0;
      lows = 0;
      for (int i = 0; i < 37; i++) begin
         @(negedge clk);
         if (hCount !== 10'd300 || vCount !== 10'd5 || hsync !== 1'b1 || vsync !== 1'b1 ||
             video_on !== 1'b1 || pixel_x !== 10'd156 || pixel_y !== 10'd0 ||
             pix_tick !== 1'b0 || line_start !== 1'b0) lows++;
      end
      check("hold_bad_samples", lows, 0);
      check("hold_hcount", hCount, 300);
      check("hold_pixel_x", pixel_x, 156);
      en = 1'b1;
      @(negedge clk);
      check("resume_edge1_hcount", hCount, 300);
      check("resume_edge1_tick", pix_tick, 0);
      @(negedge clk);
      check("resume_edge2_hcount", hCount, 301);
      check("resume_edge2_tick", pix_tick, 1);
      check("resume_pixel_x", pixel_x, 157);

      // Reset mid-frame
      found = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (pix_tick && hCount == 10'd500 && vCount == 10'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_h500_v7", found, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_hcount", hCount, 0);
      check("async_rst_vcount", vCount, 0);
      check("async_rst_hsync", hsync, 0);
      check("async_rst_vsync", vsync, 0);
      check("async_rst_video_on", video_on, 0);
      check("async_rst_pixel_x", pixel_x, 0);
      check("async_rst_pixel_y", pixel_y, 0);
      check("async_rst_pix_tick", pix_tick, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_edge1_hcount", hCount, 0);
      check("restart_edge1_fs", frame_start, 0);
      @(negedge clk);
      check("restart_edge2_hcount", hCount, 1);
      check("restart_edge2_vcount", vCount, 0);
      check("restart_edge2_ls", line_start, 0);
      check("restart_edge2_fs", frame_start, 0);

      // CLK_DIV=1: tick every clock, frame equals pixel count
      rst_n2 = 1'b1;
      @(negedge clk);
      check("div1_first_tick", pix_tick2, 1);
      check("div1_first_hcount", hCount2, 1);
      clks = 1; ticks = 1; lows = 0; found = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         clks++;
         if (pix_tick2) ticks++;
         else lows++;
         if (frame_start2) begin
            found = 1'b1;
            break;
         end
      end
      check("div1_frame_seen", found, 1);
      check("div1_frame_clks", clks, 800 * 11);
      check("div1_frame_ticks", ticks, 800 * 11);
      check("div1_tick_gaps", lows, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-002 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-003 The block SHALL have parameter H_ACT, default 640, horizontal active pixels.
REQ-004 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-005 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-006 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-007 The block SHALL have parameter V_ACT, default 480, vertical active lines.
REQ-008 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-009 The block SHALL have parameter CLK_DIV, default 2, the number of clk cycles per pixel (1..16).
REQ-010 The block SHALL have port clk, input, 1 bit, the single clock; all flops are rising-edge.
REQ-011 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-012 The block SHALL have port en, input, 1 bit; when low, the timing freezes.
REQ-013 The block SHALL have port hCount, output, 10 bits, the horizontal pixel counter.
REQ-014 The block SHALL have port vCount, output, 10 bits, the vertical line counter.
REQ-015 The block SHALL have port hsync, output, 1 bit, active-low horizontal sync.
REQ-016 The block SHALL have port vsync, output, 1 bit, active-low vertical sync.
REQ-017 The block SHALL have port video_on, output, 1 bit, high inside the active area.
REQ-018 The block SHALL have port pixel_x, output, 10 bits, the active-area column; 0 outside the area.
REQ-019 The block SHALL have port pixel_y, output, 10 bits, the active-area row; 0 outside the area.
REQ-020 The block SHALL have port pix_tick, output, 1 bit, a one-clk pulse on each pixel advance.
REQ-021 The block SHALL have port line_start, output, 1 bit, a one-clk pulse when hCount wraps to 0.
REQ-022 The block SHALL have port frame_start, output, 1 bit, a one-clk pulse when both counters wrap to 0.

Function
REQ-023 The block SHALL count clk cycles in a divider from 0 to CLK_DIV-1 while en=1, asserting pix_tick internally on the count CLK_DIV-1, then wrapping to 0.
REQ-024 The divider SHALL hold its value while en=0, and pix_tick SHALL be 0 while en=0.
REQ-025 On each pix_tick, hCount SHALL increment, and SHALL wrap to 0 after H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACT+H_FP (800 by default).
REQ-026 vCount SHALL increment only on the pix_tick that wraps hCount, and SHALL wrap to 0 after V_TOT-1, where V_TOT = V_SYNC+V_BP+V_ACT+V_FP (525 by default).
REQ-027 The horizontal FSM SHALL step H_SYNC -> H_BP -> H_ACT -> H_FP -> H_SYNC, with each transition on the pix_tick that brings hCount to H_SYNC, H_SYNC+H_BP, H_SYNC+H_BP+H_ACT, or 0 respectively.
REQ-028 The vertical FSM SHALL step V_SYNC -> V_BP -> V_ACT -> V_FP -> V_SYNC at the equivalent vCount boundaries, changing only on line wrap.
REQ-029 Sync regions SHALL be hCount in [0, H_SYNC-1] and vCount in [0, V_SYNC-1]; hsync and vsync SHALL be 0 inside these regions and 1 outside them.
REQ-030 video_on SHALL be 1 if and only if both FSMs are in their ACT state.
REQ-031 When video_on=1, pixel_x SHALL equal hCount-(H_SYNC+H_BP) and pixel_y SHALL equal vCount-(V_SYNC+V_BP).
REQ-032 All outputs SHALL be registered and decoded from next-state counter values, so they change on the same edge as hCount/vCount with zero skew.
REQ-033 line_start SHALL be high for exactly the one clk of the edge at which hCount becomes 0; frame_start SHALL additionally require vCount to become 0.
REQ-034 Counter arithmetic SHALL be unsigned 10-bit, and no counter SHALL exceed its total minus 1.
REQ-035 When en falls in the middle of a line, the block SHALL freeze all counters, FSM states and sync levels, and on resume SHALL continue from the held position without skipping or repeating.

Reset
REQ-036 Assertion of rst_n=0 SHALL immediately and asynchronously set: divider=0, hCount=0, vCount=0, H FSM=H_SYNC, V FSM=V_SYNC, hsync=0, vsync=0, video_on=0, pixel_x=0, pixel_y=0, pix_tick=0, line_start=0, frame_start=0.
REQ-037 Reset SHALL be released synchronously to clk, and the first pix_tick after release SHALL occur CLK_DIV clk cycles later.
REQ-038 Reset asserted in the middle of a frame SHALL abandon that frame, with no partial pulse completing after release.

Verification
REQ-039 The bench SHALL cover: defaults, en=1, one full frame -> exactly 420000 pix_tick pulses, 525 line_start pulses and 1 frame_start pulse, with 840000 clk cycles between frame_start pulses.
REQ-040 The bench SHALL cover: line check -> hsync=0 for hCount 0..95 and 1 at hCount=96, video_on rising at hCount=144 with pixel_x=0, and pixel_x=639 at hCount=783.
REQ-041 The bench SHALL cover: frame check -> vsync=0 for vCount 0..1, video_on rows vCount 35..514 with pixel_y 0..479, and the wrap from (799,524) to (0,0) with frame_start=1.
REQ-042 The bench SHALL cover: en=0 for 37 clk at hCount=300 -> hCount, vCount and all outputs held, with hCount=301 on the next tick after en returns to 1.
REQ-043 The bench SHALL cover: rst_n pulsed low at (hCount=500, vCount=200) -> outputs at reset values within the same cycle, and a restart from (0,0).
REQ-044 The bench SHALL cover: CLK_DIV=1 -> pix_tick high every clk, with a frame lasting 420000 clk cycles.
